hoi_pkt_gate: RTL and testbench
===============================

Name: hoi_pkt_gate

Overview:
- Store-and-forward packet buffer that feeds the host-interface byte serializer. It accepts 134-bit packet words from the switching core.
- Only complete packets are exposed to the serializer. The serializer checks empty once per frame and then pops one word per 8 or 16 cycles without rechecking, so a partial packet is never made visible.
- Packets that cannot fit, and malformed packets, are dropped whole and counted.

Parameters:
- AW, 8, address width; buffer depth DEPTH = 2^AW words.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- iv_data  in  134  packet word. [133:132]: 01 = head (metadata word), 00 = body, 10 = tail, 11 = illegal. [131:128]: invalid byte count, meaningful on tail only. [127:0]: data.
- i_data_wr  in  1  iv_data valid this cycle; no backpressure.
- ov_pkt_data  out  134  show-ahead word at the read pointer.
- i_pkt_data_rd  in  1  pop the current word (one-cycle pulse).
- o_pkt_data_empty  out  1  high when no complete packet is stored.
- ov_pkt_cnt  out  AW+1  complete packets stored.
- ov_free_words  out  AW+1  DEPTH minus (speculative write pointer minus read pointer).
- o_pkt_drop  out  1  one-cycle pulse per dropped packet.
- ov_drop_cnt  out  16  dropped-packet count, saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on i_rst.
- Reset values:
  - Pointers, ov_pkt_cnt, ov_drop_cnt, o_pkt_drop and ov_pkt_data all 0.
  - o_pkt_data_empty = 1; ov_free_words = DEPTH.
  - Write FSM = WR_IDLE; memory contents don't-care.
  - Reset mid-packet discards everything, including any partially written packet.
- Pointers: committed write pointer cwp, speculative write pointer swp, read pointer rp. All are AW+1 bits with natural wrap; the MSB distinguishes full from empty. full = (swp - rp == DEPTH).
- Write FSM states: WR_IDLE, WR_PKT, WR_DISCARD.
  - WR_IDLE:
    - Head word with !full: write mem[swp], swp++, go to WR_PKT.
    - Any other flag: ignored, no drop pulse.
    - Head word while full: drop pulse, go to WR_DISCARD.
  - WR_PKT, body or tail word with !full:
    - Write mem[swp], swp++.
    - On tail: cwp <= swp+1, ov_pkt_cnt++, go to WR_IDLE.
  - WR_PKT, word arriving while full:
    - swp <= cwp (rollback), drop pulse.
    - Go to WR_IDLE if the word is a tail, else WR_DISCARD.
  - WR_PKT, head word (previous tail missing):
    - Roll back to cwp and pulse drop.
    - Restart the packet with this head written at cwp; stay in WR_PKT.
  - WR_PKT, illegal flag 11: rollback, drop pulse, go to WR_DISCARD.
  - WR_DISCARD:
    - Words are ignored until a tail, then go to WR_IDLE.
    - A head word restarts as in WR_IDLE, with no extra drop pulse.
- ov_drop_cnt increments on every o_pkt_drop pulse and saturates.
- Read side:
  - ov_pkt_data is registered every cycle from mem[rp_next]. rp_next = rp+1 when a pop is accepted, else rp.
  - The next word is therefore valid in the cycle immediately after the pop cycle, with zero bubble.
  - A pop is accepted when i_pkt_data_rd && ov_pkt_cnt != 0; otherwise it is ignored with no pointer change.
  - A popped word with flag 10 decrements ov_pkt_cnt.
  - Pops never pass cwp: the serializer pops only within committed packets.
- Commit latency: for a tail written in cycle T, ov_pkt_cnt updates at the end of T. o_pkt_data_empty = (ov_pkt_cnt == 0) is registered, so it goes low in cycle T+2. ov_pkt_data already shows the head word by then, because write-first has completed.
- Simultaneous tail commit and tail pop: ov_pkt_cnt is unchanged and empty is unchanged.
- Write at mem[swp] while rp reads a different address: no hazard. swp equals rp only when the memory is empty of uncommitted data.
- ov_free_words is combinational from swp and rp.
- Memory: simple dual-port, inferable as block RAM with registered read.

Test Plan:
- Single packet: reset, then write head, 3 body words, and tail with [131:128] = 4 in consecutive cycles. Required: empty falls 2 cycles after the tail write, ov_pkt_cnt = 1, ov_pkt_data = head word. Popping every 8 cycles returns the 5 words in order; after the tail pop, ov_pkt_cnt = 0 and empty rises 2 cycles later.
- Zero-bubble read: with 2 packets stored, pop in consecutive cycles. Required: ov_pkt_data advances each cycle, and empty stays 0 until the second tail is popped.
- Overflow, AW = 4 (DEPTH 16): store a 10-word packet, then write a 10-word packet. Required: the 7th word hits full, drop pulse, ov_drop_cnt = 1, swp rolls back, ov_free_words = 6. The first packet reads intact, and a following 4-word packet is accepted.
- Missing tail: head, 2 body, head, 1 body, tail. Required: one drop; only the second, 3-word packet is stored; ov_pkt_cnt = 1.
- Stray words: body and tail words in WR_IDLE, and a packet containing flag 11. Required: strays are ignored with no drop pulse; the flag-11 packet gives exactly one drop and nothing is stored.
- Simultaneous commit and pop: tail write and tail pop in the same cycle with ov_pkt_cnt = 1. Required: ov_pkt_cnt stays 1. Also assert i_rst mid-packet: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/hoi_pkt_if.sv
// Packet buffer bus between the switching core / host serializer and hoi_pkt_gate.
//   iv_data, i_data_wr     : 134-bit packet word and its write strobe (no backpressure)
//   ov_pkt_data            : show-ahead word at the read pointer
//   i_pkt_data_rd          : pop strobe from the serializer
//   o_pkt_data_empty       : no complete packet stored (registered)
//   ov_pkt_cnt             : complete packets stored
//   ov_free_words          : words not yet claimed by committed or in-flight packets
//   o_pkt_drop, ov_drop_cnt: drop pulse and saturating drop count
// master drives the write/pop side; slave is the buffer itself.
interface hoi_pkt_if #(
   parameter int AW = 8
);
   logic [133:0] iv_data;
   logic         i_data_wr;
   logic [133:0] ov_pkt_data;
   logic         i_pkt_data_rd;
   logic         o_pkt_data_empty;
   logic [AW:0]  ov_pkt_cnt;
   logic [AW:0]  ov_free_words;
   logic         o_pkt_drop;
   logic [15:0]  ov_drop_cnt;

   modport master (
      output iv_data, i_data_wr, i_pkt_data_rd,
      input  ov_pkt_data, o_pkt_data_empty, ov_pkt_cnt, ov_free_words,
             o_pkt_drop, ov_drop_cnt
   );

   modport slave (
      input  iv_data, i_data_wr, i_pkt_data_rd,
      output ov_pkt_data, o_pkt_data_empty, ov_pkt_cnt, ov_free_words,
             o_pkt_drop, ov_drop_cnt
   );
endinterface

// File: rtl/hoi_pkt_gate.sv
// Store-and-forward packet gate in front of the host byte serializer.
// Words of a packet are written speculatively and only become visible to the
// reader once the tail lands; packets that overflow or are malformed are
// rolled back whole and counted.
//
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous reset, active-high
//   bus    : hoi_pkt_if slave (write port, show-ahead read port, status)
//
// Write FSM
//   state      | meaning
//   WR_IDLE    | between packets, waiting for a head word
//   WR_PKT     | packet in flight, words land at swp beyond cwp
//   WR_DISCARD | current packet abandoned, skipping to its tail
module hoi_pkt_gate #(
   parameter int AW = 8
) (
   input  logic     i_clk,
   input  logic     i_rst,
   hoi_pkt_if.slave bus
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);

   localparam logic [1:0] FLG_BODY = 2'b00;
   localparam logic [1:0] FLG_HEAD = 2'b01;
   localparam logic [1:0] FLG_TAIL = 2'b10;
   localparam logic [1:0] FLG_ILL  = 2'b11;

   typedef enum logic [1:0] {
      WR_IDLE    = 2'd0,
      WR_PKT     = 2'd1,
      WR_DISCARD = 2'd2
   } wr_state_e;

   wr_state_e    state_q, state_d;
   logic [AW:0]  swp_q, swp_d;
   logic [AW:0]  cwp_q, cwp_d;
   logic [AW:0]  rp_q, rp_d;
   logic [AW:0]  pkt_cnt_q, pkt_cnt_d;
   logic [15:0]  drop_cnt_q, drop_cnt_d;
   logic         drop_q, drop_d;
   logic         empty_q, empty_d;
   logic [133:0] rdata_q, rdata_d;

   logic [133:0] mem [DEPTH];

   logic          we;
   logic [AW-1:0] waddr;
   logic          commit;
   logic          pop;
   logic          pop_tail;
   logic [AW:0]   used;
   logic          full;
   logic [1:0]    flag;

   assign used = swp_q - rp_q;
   assign full = (used == DEPTH_W);
   assign flag = bus.iv_data[133:132];

   // Write side: speculative fill at swp, commit by moving cwp on the tail,
   // rollback by restoring swp from cwp.
   always_comb begin
      state_d = state_q;
      swp_d   = swp_q;
      cwp_d   = cwp_q;
      we      = 1'b0;
      waddr   = swp_q[AW-1:0];
      drop_d  = 1'b0;
      commit  = 1'b0;

      if (bus.i_data_wr) begin
         unique case (state_q)
            WR_IDLE, WR_DISCARD: begin
               if (flag == FLG_HEAD) begin
                  if (!full) begin
                     we      = 1'b1;
                     swp_d   = swp_q + ONE_W;
                     state_d = WR_PKT;
                  end else begin
                     drop_d  = 1'b1;
                     state_d = WR_DISCARD;
                  end
               end else if (state_q == WR_DISCARD && flag == FLG_TAIL) begin
                  state_d = WR_IDLE;
               end
            end

            WR_PKT: begin
               if (flag == FLG_ILL) begin
                  swp_d   = cwp_q;
                  drop_d  = 1'b1;
                  state_d = WR_DISCARD;
               end else if (flag == FLG_HEAD) begin
                  // Tail of the previous packet never came. The in-flight
                  // packet always holds at least its head, so rolling back
                  // always frees room for the new head at cwp.
                  drop_d = 1'b1;
                  we     = 1'b1;
                  waddr  = cwp_q[AW-1:0];
                  swp_d  = cwp_q + ONE_W;
               end else if (full) begin
                  swp_d   = cwp_q;
                  drop_d  = 1'b1;
                  state_d = (flag == FLG_TAIL) ? WR_IDLE : WR_DISCARD;
               end else begin
                  we    = 1'b1;
                  swp_d = swp_q + ONE_W;
                  if (flag == FLG_TAIL) begin
                     cwp_d   = swp_q + ONE_W;
                     commit  = 1'b1;
                     state_d = WR_IDLE;
                  end
               end
            end

            default: state_d = WR_IDLE;
         endcase
      end
   end

   // Read side: ov_pkt_data is reloaded every cycle from the address the
   // pointer is about to hold, which gives a zero-bubble pop stream.
   always_comb begin
      pop      = bus.i_pkt_data_rd && (pkt_cnt_q != '0);
      pop_tail = pop && (rdata_q[133:132] == FLG_TAIL);
      rp_d     = pop ? rp_q + ONE_W : rp_q;

      pkt_cnt_d = pkt_cnt_q;
      unique case ({commit, pop_tail})
         2'b10:   pkt_cnt_d = pkt_cnt_q + ONE_W;
         2'b01:   pkt_cnt_d = pkt_cnt_q - ONE_W;
         default: pkt_cnt_d = pkt_cnt_q;
      endcase

      drop_cnt_d = drop_cnt_q;
      if (drop_d && drop_cnt_q != 16'hFFFF) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end

      empty_d = (pkt_cnt_q == '0);

      // Write-first: a word landing at the read address this cycle is
      // forwarded straight to the output register.
      if (we && waddr == rp_d[AW-1:0]) begin
         rdata_d = bus.iv_data;
      end else begin
         rdata_d = mem[rp_d[AW-1:0]];
      end
   end

   always_ff @(posedge i_clk) begin
      if (we) begin
         mem[waddr] <= bus.iv_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= WR_IDLE;
         swp_q      <= '0;
         cwp_q      <= '0;
         rp_q       <= '0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
         drop_q     <= 1'b0;
         empty_q    <= 1'b1;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         swp_q      <= swp_d;
         cwp_q      <= cwp_d;
         rp_q       <= rp_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         drop_q     <= drop_d;
         empty_q    <= empty_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.ov_pkt_data      = rdata_q;
   assign bus.o_pkt_data_empty = empty_q;
   assign bus.ov_pkt_cnt       = pkt_cnt_q;
   assign bus.ov_free_words    = DEPTH_W - used;
   assign bus.o_pkt_drop       = drop_q;
   assign bus.ov_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_hoi_pkt_gate.sv
module tb_hoi_pkt_gate;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   localparam logic [1:0] BODY = 2'b00;
   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] TAIL = 2'b10;
   localparam logic [1:0] ILL  = 2'b11;

   logic i_clk = 1'b0;
   logic i_rst;

   hoi_pkt_if #(.AW(AW)) bus ();

   hoi_pkt_gate #(.AW(AW)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   logic [133:0] mq[$];     // committed, unread words
   logic [133:0] pend[$];   // words of the packet in flight
   int m_mode;              // 0 idle, 1 in packet, 2 discarding
   int m_cnt, m_dcnt, m_drop, m_empty;
   bit model_on = 0;

   task automatic model_reset();
      mq.delete();
      pend.delete();
      m_mode = 0; m_cnt = 0; m_dcnt = 0; m_drop = 0; m_empty = 1;
   endtask

   task automatic model_drop();
      m_drop = 1;
      if (m_dcnt < 65535) m_dcnt++;
   endtask

   task automatic model_step(logic rst, logic wr, logic [133:0] w, logic rd);
      int cnt0;
      bit full;
      logic [1:0] f;
      logic [133:0] wo;
      if (rst) begin
         model_reset();
         return;
      end
      cnt0   = m_cnt;
      full   = (mq.size() + pend.size() == DEPTH);
      f      = w[133:132];
      m_drop = 0;
      if (rd && m_cnt != 0) begin
         wo = mq.pop_front();
         if (wo[133:132] == TAIL) m_cnt--;
      end
      if (wr) begin
         if (m_mode == 1) begin
            if (f == ILL) begin
               pend.delete(); model_drop(); m_mode = 2;
            end else if (f == HEAD) begin
               pend.delete(); model_drop(); pend.push_back(w);
            end else if (full) begin
               pend.delete(); model_drop(); m_mode = (f == TAIL) ? 0 : 2;
            end else begin
               pend.push_back(w);
               if (f == TAIL) begin
                  foreach (pend[i]) mq.push_back(pend[i]);
                  pend.delete();
                  m_cnt++;
                  m_mode = 0;
               end
            end
         end else if (f == HEAD) begin
            if (!full) begin
               pend.push_back(w); m_mode = 1;
            end else begin
               model_drop(); m_mode = 2;
            end
         end else if (m_mode == 2 && f == TAIL) begin
            m_mode = 0;
         end
      end
      m_empty = (cnt0 == 0);
   endtask

   // ---------------- helpers ----------------
   function automatic logic [127:0] pl(int tag);
      return {96'hC0DE_5A5A_0F0F_1234_9876_ABCD, 32'(tag)};
   endfunction

   function automatic logic [133:0] mk(logic [1:0] f, logic [3:0] inv, int tag);
      return {f, inv, pl(tag)};
   endfunction

   task automatic chk_i(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_d(string name, logic [133:0] act, logic [133:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_st(string name, int cnt, int free, int drop, int dcnt, int empty);
      chk_i({name, "_cnt"},   int'(bus.ov_pkt_cnt),       cnt);
      chk_i({name, "_free"},  int'(bus.ov_free_words),    free);
      chk_i({name, "_drop"},  int'(bus.o_pkt_drop),       drop);
      chk_i({name, "_dcnt"},  int'(bus.ov_drop_cnt),      dcnt);
      chk_i({name, "_empty"}, int'(bus.o_pkt_data_empty), empty);
   endtask

   task automatic cyc(logic rst, logic wr, logic [133:0] d, logic rd);
      i_rst             = rst;
      bus.i_data_wr     = wr;
      bus.iv_data       = d;
      bus.i_pkt_data_rd = rd;
      @(posedge i_clk);
      if (model_on) model_step(rst, wr, d, rd);
      @(negedge i_clk);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic wrw(logic [1:0] f, int tag);
      cyc(1'b0, 1'b1, mk(f, (f == TAIL) ? 4'd4 : 4'd0, tag), 1'b0);
   endtask

   task automatic popw();
      cyc(1'b0, 1'b0, '0, 1'b1);
   endtask

   function automatic logic [1:0] pkt_flag(int i, int n);
      if (i == 0) return HEAD;
      if (i == n - 1) return TAIL;
      return BODY;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      int wr; logic [1:0] f; int tag;
      int cnt; int free; int drop; int dcnt; int empty; int dtag;
   } vec_t;

   function automatic vec_t v(int wr, logic [1:0] f, int tag, int cnt, int free,
                              int drop, int dcnt, int empty, int dtag);
      vec_t r;
      r.wr = wr; r.f = f; r.tag = tag; r.cnt = cnt; r.free = free;
      r.drop = drop; r.dcnt = dcnt; r.empty = empty; r.dtag = dtag;
      return r;
   endfunction

   initial begin
      vec_t tv[$];
      int zb_tags[5];
      int ov_tags[$];

      i_rst = 1'b1; bus.i_data_wr = 1'b0; bus.iv_data = '0; bus.i_pkt_data_rd = 1'b0;

      // ---- reset values and single packet ----
      cyc(1'b1, 1'b0, '0, 1'b0);
      chk_st("rst", 0, DEPTH, 0, 0, 1);
      chk_d("rst_data", bus.ov_pkt_data, '0);
      for (int i = 0; i < 5; i++) wrw(pkt_flag(i, 5), 100 + i);
      chk_st("sp_tail", 1, 11, 0, 0, 1);
      idle();
      chk_i("sp_empty_t2", int'(bus.o_pkt_data_empty), 0);
      chk_d("sp_head", bus.ov_pkt_data, mk(HEAD, 4'd0, 100));
      for (int k = 0; k < 5; k++) begin
         chk_d("sp_pop_data", bus.ov_pkt_data,
               mk(pkt_flag(k, 5), (k == 4) ? 4'd4 : 4'd0, 100 + k));
         popw();
         if (k == 4) begin
            chk_i("sp_cnt_after", int'(bus.ov_pkt_cnt), 0);
            chk_i("sp_empty_t1", int'(bus.o_pkt_data_empty), 0);
         end
         idle();
         if (k == 4) chk_i("sp_empty_t2_rise", int'(bus.o_pkt_data_empty), 1);
         for (int j = 0; j < 6; j++) idle();
      end
      chk_i("sp_free_end", int'(bus.ov_free_words), DEPTH);

      // ---- strays, missing tail, illegal flag ----
      cyc(1'b1, 1'b0, '0, 1'b0);
      tv.push_back(v(1, BODY,  1, 0, 16, 0, 0, 1, -1));
      tv.push_back(v(1, TAIL,  2, 0, 16, 0, 0, 1, -1));
      tv.push_back(v(1, HEAD, 10, 0, 15, 0, 0, 1, -1));
      tv.push_back(v(1, BODY, 11, 0, 14, 0, 0, 1, -1));
      tv.push_back(v(1, BODY, 12, 0, 13, 0, 0, 1, -1));
      tv.push_back(v(1, HEAD, 20, 0, 15, 1, 1, 1, -1));
      tv.push_back(v(1, BODY, 21, 0, 14, 0, 1, 1, -1));
      tv.push_back(v(1, TAIL, 22, 1, 13, 0, 1, 1, 20));
      tv.push_back(v(0, BODY,  0, 1, 13, 0, 1, 0, 20));
      tv.push_back(v(1, HEAD, 30, 1, 12, 0, 1, 0, -1));
      tv.push_back(v(1, BODY, 31, 1, 11, 0, 1, 0, -1));
      tv.push_back(v(1, ILL,  32, 1, 13, 1, 2, 0, -1));
      tv.push_back(v(1, BODY, 33, 1, 13, 0, 2, 0, -1));
      tv.push_back(v(1, TAIL, 34, 1, 13, 0, 2, 0, -1));
      tv.push_back(v(1, BODY, 35, 1, 13, 0, 2, 0, 20));
      foreach (tv[i]) begin
         cyc(1'b0, tv[i].wr != 0, mk(tv[i].f, (tv[i].f == TAIL) ? 4'd4 : 4'd0, tv[i].tag), 1'b0);
         chk_st($sformatf("vec%0d", i), tv[i].cnt, tv[i].free, tv[i].drop, tv[i].dcnt, tv[i].empty);
         if (tv[i].dtag >= 0) chk_d($sformatf("vec%0d_data", i), {6'd0, bus.ov_pkt_data[127:0]}, {6'd0, pl(tv[i].dtag)});
      end

      // ---- zero-bubble read of two packets ----
      wrw(HEAD, 40);
      wrw(TAIL, 41);
      idle(); idle();
      chk_st("zb_pre", 2, 11, 0, 2, 0);
      zb_tags = '{20, 21, 22, 40, 41};
      for (int k = 0; k < 5; k++) begin
         chk_d("zb_data", {6'd0, bus.ov_pkt_data[127:0]}, {6'd0, pl(zb_tags[k])});
         chk_i("zb_cnt", int'(bus.ov_pkt_cnt), (k < 3) ? 2 : 1);
         chk_i("zb_empty", int'(bus.o_pkt_data_empty), 0);
         popw();
      end
      chk_i("zb_cnt_end", int'(bus.ov_pkt_cnt), 0);
      chk_i("zb_empty_t1", int'(bus.o_pkt_data_empty), 0);
      idle();
      chk_i("zb_empty_t2", int'(bus.o_pkt_data_empty), 1);

      // ---- overflow ----
      cyc(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 10; i++) wrw(pkt_flag(i, 10), 200 + i);
      chk_st("ov_first", 1, 6, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         wrw(pkt_flag(i, 10), 300 + i);
         if (i == 5) chk_st("ov_full", 1, 0, 0, 0, 0);
         if (i == 6) chk_st("ov_hit", 1, 6, 1, 1, 0);
      end
      chk_st("ov_after", 1, 6, 0, 1, 0);
      for (int i = 0; i < 4; i++) wrw(pkt_flag(i, 4), 400 + i);
      idle(); idle();
      chk_st("ov_small", 2, 2, 0, 1, 0);
      for (int i = 0; i < 10; i++) ov_tags.push_back(200 + i);
      for (int i = 0; i < 4; i++) ov_tags.push_back(400 + i);
      foreach (ov_tags[k]) begin
         chk_d("ov_read", {6'd0, bus.ov_pkt_data[127:0]}, {6'd0, pl(ov_tags[k])});
         popw();
      end
      chk_i("ov_cnt_end", int'(bus.ov_pkt_cnt), 0);
      chk_i("ov_free_end", int'(bus.ov_free_words), DEPTH);

      // ---- simultaneous commit and tail pop ----
      cyc(1'b1, 1'b0, '0, 1'b0);
      wrw(HEAD, 500);
      wrw(TAIL, 501);
      idle(); idle();
      chk_d("sim_data0", {6'd0, bus.ov_pkt_data[127:0]}, {6'd0, pl(500)});
      cyc(1'b0, 1'b1, mk(HEAD, 4'd0, 600), 1'b1);
      chk_i("sim_cnt_a", int'(bus.ov_pkt_cnt), 1);
      cyc(1'b0, 1'b1, mk(TAIL, 4'd0, 601), 1'b1);
      chk_i("sim_cnt_b", int'(bus.ov_pkt_cnt), 1);
      chk_d("sim_data1", {6'd0, bus.ov_pkt_data[127:0]}, {6'd0, pl(600)});
      idle();
      chk_i("sim_cnt_c", int'(bus.ov_pkt_cnt), 1);
      chk_i("sim_empty", int'(bus.o_pkt_data_empty), 0);

      // ---- reset in the middle of a packet ----
      wrw(HEAD, 700);
      wrw(HEAD, 701);
      chk_i("mr_drop", int'(bus.o_pkt_drop), 1);
      cyc(1'b1, 1'b1, mk(BODY, 4'd0, 702), 1'b0);
      chk_st("mr_rst", 0, DEPTH, 0, 0, 1);
      chk_d("mr_data", bus.ov_pkt_data, '0);
      wrw(TAIL, 703);
      chk_st("mr_stray", 0, DEPTH, 0, 0, 1);

      // ---- randomized against the reference model ----
      model_on = 1;
      cyc(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 4000; i++) begin
         int r;
         logic [1:0] f;
         logic wr, rd;
         r  = int'($urandom_range(0, 99));
         f  = (r < 20) ? HEAD : (r < 72) ? BODY : (r < 95) ? TAIL : ILL;
         wr = ($urandom_range(0, 3) != 0);
         rd = ((i / 400) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
         cyc(1'b0, wr, {f, 4'($urandom), $urandom, $urandom, $urandom, $urandom}, rd);
         chk_i("rnd_cnt",   int'(bus.ov_pkt_cnt),       m_cnt);
         chk_i("rnd_free",  int'(bus.ov_free_words),    DEPTH - mq.size() - pend.size());
         chk_i("rnd_drop",  int'(bus.o_pkt_drop),       m_drop);
         chk_i("rnd_dcnt",  int'(bus.ov_drop_cnt),      m_dcnt);
         chk_i("rnd_empty", int'(bus.o_pkt_data_empty), m_empty);
         if (m_cnt > 0) chk_d("rnd_data", bus.ov_pkt_data, mq[0]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
